// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared constants and writeback request type for the regfile
//          writeback arbiter.
// Rev    : 1.0
// ============================================================================
package regfile_pkg;

  localparam int NREQ_MAX   = 4;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int PTR_W      = $clog2(NREQ_MAX);
  // Data field is sized for the widest supported register (XLEN <= 64).
  localparam int WB_DATA_W  = 64;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; searches upward from ptr and
//          returns a one-hot (or zero) grant.
// Rev    : 1.0
// ============================================================================
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N       = 3,
  parameter int PTR_W_P = PTR_W
) (
  input  logic [N-1:0]       req,
  input  logic [PTR_W_P-1:0] ptr,
  output logic [N-1:0]       gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(ptr) + off) % N) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Round-robin writeback arbiter with busy scoreboard and registered
//          regfile write port. Optional forwarding via REGFILE_WB_FWD_EN.
// Rev    : 1.0
// ============================================================================
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NREQ-1:0]                     req_valid,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0]     req_addr,
  input  logic [NREQ-1:0][XLEN-1:0]           req_data,
  output logic [NREQ-1:0]                     req_ready,
  input  logic                                rsv_valid,
  input  logic [REG_ADDR_W-1:0]               rsv_addr,
  input  logic                                flush,
  output logic [NUM_REGS-1:0]                 busy,
`ifdef REGFILE_WB_FWD_EN
  input  logic [REG_ADDR_W-1:0]               ra1,
  input  logic [REG_ADDR_W-1:0]               ra2,
  output logic                                fwd1_hit,
  output logic                                fwd2_hit,
  output logic [XLEN-1:0]                     fwd_data,
`endif
  output logic                                we3,
  output logic [REG_ADDR_W-1:0]               wa3,
  output logic [XLEN-1:0]                     wd3
);

  logic [NREQ-1:0]       arb_gnt;
  logic [NREQ-1:0]       gnt;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      sel_idx;
  wb_req_t               sel;
  logic [WB_DATA_W-1:0]  sel_data;

  logic                  we3_q, we3_d;
  logic [REG_ADDR_W-1:0] wa3_q, wa3_d;
  logic [XLEN-1:0]       wd3_q, wd3_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  rr_arbiter #(
    .N       (NREQ),
    .PTR_W_P (PTR_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  // Flush suppresses every grant, so nothing transfers and rr_ptr holds.
  assign gnt       = flush ? '0 : arb_gnt;
  assign req_ready = gnt;

  always_comb begin
    sel     = '0;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i] && req_valid[i]) begin
        sel.valid = 1'b1;
        sel.addr  = req_addr[i];
        sel.data  = WB_DATA_W'(req_data[i]);
        sel_idx   = PTR_W'(i);
      end
    end
  end

  assign sel_data = sel.data;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    busy_d   = busy_q;
    if (sel.valid) begin
      rr_ptr_d            = (sel_idx == PTR_W'(NREQ - 1)) ? '0 : sel_idx + PTR_W'(1);
      we3_d               = (sel.addr != '0);
      wa3_d               = sel.addr;
      wd3_d               = XLEN'(sel_data);
      busy_d[sel.addr]    = 1'b0;
    end
    // Applied after the clear so a same-address reservation wins.
    if (rsv_valid) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      busy_q   <= busy_d;
    end
  end

  assign we3  = we3_q;
  assign wa3  = wa3_q;
  assign wd3  = wd3_q;
  assign busy = busy_q;

`ifdef REGFILE_WB_FWD_EN
  assign fwd1_hit = we3_q && (wa3_q == ra1) && (ra1 != '0);
  assign fwd2_hit = we3_q && (wa3_q == ra2) && (ra2 != '0);
  assign fwd_data = wd3_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_wb_arbiter
// Brief  : Scoreboard bench for regfile_wb_arbiter (optional REGFILE_WB_FWD_EN).
// Rev    : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                            clk = 1'b0;
  logic                            reset_n;
  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0][REG_ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][XLEN-1:0]       req_data;
  logic [NREQ-1:0]                 req_ready;
  logic                            rsv_valid;
  logic [REG_ADDR_W-1:0]           rsv_addr;
  logic                            flush;
  logic [NUM_REGS-1:0]             busy;
  logic                            we3;
  logic [REG_ADDR_W-1:0]           wa3;
  logic [XLEN-1:0]                 wd3;
`ifdef REGFILE_WB_FWD_EN
  logic [REG_ADDR_W-1:0]           ra1, ra2;
  logic                            fwd1_hit, fwd2_hit;
  logic [XLEN-1:0]                 fwd_data;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .busy      (busy),
`ifdef REGFILE_WB_FWD_EN
    .ra1       (ra1),
    .ra2       (ra2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd_data  (fwd_data),
`endif
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3)
  );

  typedef struct {
    logic                  we;
    logic [REG_ADDR_W-1:0] wa;
    logic [XLEN-1:0]       wd;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          m_ptr    = 0;
  logic [31:0] m_busy   = '0;

  function automatic logic [NREQ-1:0] rr_model(input logic [NREQ-1:0] v, input int p);
    logic [NREQ-1:0] r;
    r = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) begin
        r[(p + k) % NREQ] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    return flush ? '0 : rr_model(req_valid, m_ptr);
  endfunction

  // Predicts the edge from the current inputs, queues the expected write, then clocks.
  task automatic model_edge();
    exp_t            e;
    logic [NREQ-1:0] g;
    e.we = 1'b0; e.wa = '0; e.wd = '0;
    g = exp_ready();
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        e.we  = (req_addr[i] != 5'd0);
        e.wa  = req_addr[i];
        e.wd  = req_data[i];
        m_ptr = (i + 1) % NREQ;
        m_busy[req_addr[i]] = 1'b0;
      end
    end
    if (!flush && rsv_valid) m_busy[rsv_addr] = 1'b1;
    if (flush) m_busy = '0;
    m_busy[0] = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    flush     = 1'b0;
`ifdef REGFILE_WB_FWD_EN
    ra1 = '0;
    ra2 = '0;
`endif
  endtask

  task automatic test_reset();
    idle();
    reset_n   = 1'b0;
    req_valid = 3'b010;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin failures++; $display("FAIL reset_ready: got %b want %b", req_ready, 3'b010); end
    checks++;
    if (we3 !== 1'b0 || wa3 !== 5'd0 || wd3 !== 32'd0) begin
      failures++; $display("FAIL reset_wport: got we3=%b wa3=%0d wd3=%h want 0/0/0", we3, wa3, wd3);
    end
    checks++;
    if (busy !== 32'd0) begin failures++; $display("FAIL reset_busy: got %h want 0", busy); end
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    int   seq [4] = '{0, 1, 2, 0};
    exp_t e;
    idle();
    req_valid   = 3'b111;
    req_addr[0] = 5'd1; req_addr[1] = 5'd2; req_addr[2] = 5'd3;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NREQ; i++) req_data[i] = 32'hA000_0000 | (c << 8) | i;
      #1;
      checks++;
      if (req_ready !== (3'b001 << seq[c])) begin
        failures++; $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, 3'b001 << seq[c]);
      end
      model_edge();
      e = sb.pop_front();
      checks++;
      if (we3 !== e.we || wa3 !== e.wa || wd3 !== e.wd) begin
        failures++; $display("FAIL rr_write c=%0d: got %b/%0d/%h want %b/%0d/%h", c, we3, wa3, wd3, e.we, e.wa, e.wd);
      end
    end
    idle();
  endtask

  task automatic test_rsv_then_write();
    exp_t e;
    idle();
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    model_edge();
    e = sb.pop_front();
    checks++;
    if (busy[5] !== 1'b1 || we3 !== e.we) begin failures++; $display("FAIL rsv_set: got busy5=%b we3=%b want 1/0", busy[5], we3); end
    idle();
    req_valid = 3'b001; req_addr[0] = 5'd5; req_data[0] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (req_ready !== exp_ready()) begin failures++; $display("FAIL rsv_ready: got %b want %b", req_ready, exp_ready()); end
    model_edge();
    e = sb.pop_front();
    checks++;
    if (busy[5] !== 1'b0) begin failures++; $display("FAIL rsv_clear: got busy5=%b want 0", busy[5]); end
    checks++;
    if (we3 !== 1'b1 || wa3 !== 5'd5 || wd3 !== 32'hDEAD_BEEF || wd3 !== e.wd) begin
      failures++; $display("FAIL rsv_write: got %b/%0d/%h want 1/5/deadbeef", we3, wa3, wd3);
    end
    idle();
  endtask

  task automatic test_set_wins();
    exp_t e;
    idle();
    req_valid = 3'b010; req_addr[1] = 5'd7; req_data[1] = 32'h7777_0007;
    rsv_valid = 1'b1;   rsv_addr = 5'd7;
    model_edge();
    e = sb.pop_front();
    checks++;
    if (busy[7] !== 1'b1 || busy !== m_busy) begin failures++; $display("FAIL set_wins: got busy=%h want %h", busy, m_busy); end
    checks++;
    if (we3 !== e.we || wa3 !== e.wa || wd3 !== e.wd) begin
      failures++; $display("FAIL set_wins_write: got %b/%0d/%h want %b/%0d/%h", we3, wa3, wd3, e.we, e.wa, e.wd);
    end
    idle();
  endtask

  task automatic test_r0();
    exp_t e;
    idle();
    req_valid = 3'b100; req_addr[2] = 5'd0; req_data[2] = 32'h0000_1234;
    rsv_valid = 1'b1;   rsv_addr = 5'd0;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin failures++; $display("FAIL r0_ready: got %b want 100", req_ready); end
    model_edge();
    e = sb.pop_front();
    checks++;
    if (we3 !== 1'b0 || we3 !== e.we) begin failures++; $display("FAIL r0_we: got %b want 0", we3); end
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL r0_busy: got %b want 0", busy[0]); end
    idle();
  endtask

  task automatic test_flush();
    exp_t e;
    idle();
    for (int r = 4; r < 8; r++) begin
      rsv_valid = 1'b1; rsv_addr = 5'(r);
      if (r == 7) begin req_valid = 3'b001; req_addr[0] = 5'd10; req_data[0] = 32'hCAFE_0010; end
      model_edge();
      e = sb.pop_front();
    end
    checks++;
    if (busy !== 32'h0000_00F0) begin failures++; $display("FAIL flush_pre_busy: got %h want 000000f0", busy); end
    flush = 1'b1; req_valid = 3'b111; rsv_valid = 1'b1; rsv_addr = 5'd3;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin failures++; $display("FAIL flush_ready: got %b want 000", req_ready); end
    checks++;
    if (we3 !== 1'b1 || wa3 !== 5'd10 || wd3 !== 32'hCAFE_0010) begin
      failures++; $display("FAIL flush_prior_write: got %b/%0d/%h want 1/10/cafe0010", we3, wa3, wd3);
    end
    model_edge();
    e = sb.pop_front();
    checks++;
    if (busy !== 32'd0 || we3 !== e.we) begin failures++; $display("FAIL flush_clear: got busy=%h we3=%b want 0/0", busy, we3); end
    flush = 1'b0;
    #1;
    checks++;
    if (req_ready !== exp_ready()) begin failures++; $display("FAIL flush_ptr_hold: got %b want %b", req_ready, exp_ready()); end
    idle();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    idle();
    req_valid = 3'b001; req_addr[0] = 5'd12; req_data[0] = 32'h5555_AAAA;
    rsv_valid = 1'b1;   rsv_addr = 5'd20;
    model_edge();
    e = sb.pop_front();
    checks++;
    if (we3 !== 1'b1 || wa3 !== e.wa) begin failures++; $display("FAIL mid_pre_write: got %b/%0d want 1/%0d", we3, wa3, e.wa); end
    idle();
    reset_n = 1'b0;
    #1;
    checks++;
    if (we3 !== 1'b0 || busy !== 32'd0) begin failures++; $display("FAIL mid_reset: got we3=%b busy=%h want 0/0", we3, busy); end
    m_ptr = 0; m_busy = '0; sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    model_edge();
    e = sb.pop_front();
    checks++;
    if (we3 !== 1'b0) begin failures++; $display("FAIL mid_post_we: got %b want 0", we3); end
    req_valid = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin failures++; $display("FAIL mid_ptr_reset: got %b want 001", req_ready); end
    idle();
  endtask

`ifdef REGFILE_WB_FWD_EN
  task automatic test_fwd();
    exp_t e;
    idle();
    req_valid = 3'b010; req_addr[1] = 5'd9; req_data[1] = 32'h0909_9090;
    model_edge();
    e = sb.pop_front();
    ra1 = 5'd9; ra2 = 5'd8;
    #1;
    checks++;
    if (fwd1_hit !== 1'b1 || fwd_data !== e.wd) begin
      failures++; $display("FAIL fwd1: got hit=%b data=%h want 1/%h", fwd1_hit, fwd_data, e.wd);
    end
    checks++;
    if (fwd2_hit !== 1'b0) begin failures++; $display("FAIL fwd2: got %b want 0", fwd2_hit); end
    idle();
  endtask
`endif

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 40; c++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i] = 5'($urandom);
        req_data[i] = $urandom;
      end
      rsv_valid = 1'($urandom);
      rsv_addr  = 5'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin failures++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, req_ready, exp_ready()); end
      model_edge();
      e = sb.pop_front();
      checks++;
      if (we3 !== e.we || (e.we && (wa3 !== e.wa || wd3 !== e.wd))) begin
        failures++; $display("FAIL b2b_write c=%0d: got %b/%0d/%h want %b/%0d/%h", c, we3, wa3, wd3, e.we, e.wa, e.wd);
      end
      checks++;
      if (busy !== m_busy) begin failures++; $display("FAIL b2b_busy c=%0d: got %h want %h", c, busy, m_busy); end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_rsv_then_write();
    test_set_wins();
    test_r0();
    test_flush();
    test_reset_mid();
`ifdef REGFILE_WB_FWD_EN
    test_fwd();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
